hex_ascii_tx_formatter: RTL and testbench
=========================================

Name: hex_ascii_tx_formatter

Overview:
Converts binary words into ASCII hexadecimal characters, most significant nibble first, and emits them as a byte stream. An optional CR/LF terminator follows each word. It is the transmit-side counterpart of the hex-character-to-nibble converter and feeds the UART/debug byte path. It uses a valid/ready handshake on both the input and output sides.

Parameters:
WORD_WIDTH, 16, input word width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
ADD_CRLF, 1, 1 = append 0x0D, 0x0A after the last hex character; 0 = no terminator
UPPERCASE, 1, 1 = digits A-F encoded as 0x41-0x46; 0 = 0x61-0x66

Ports:
CLK  input  1  clock
RST_N  input  1  reset, asynchronous, active-low
iVALID  input  1  input word valid
iREADY  output  1  block can accept a word
iDATA  input  WORD_WIDTH  binary word to format
oVALID  output  1  output character valid
oREADY  input  1  downstream accepts character
oDATA  output  8  ASCII character
oLAST  output  1  marks the final character of a word (LF if ADD_CRLF=1, else the last hex char)
oBUSY  output  1  word in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, iREADY=0 during reset then 1, oVALID=0, oDATA=0x00, oLAST=0, oBUSY=0, word register and nibble counter cleared.
- A word in flight when reset asserts is discarded. No partial output follows reset release.
- Constants: NIB = WORD_WIDTH/4. The nibble counter is $clog2(NIB)+1 bits wide.
- States:
  - IDLE: iREADY=1, oVALID=0. On iVALID&&iREADY, latch iDATA, set counter=NIB-1, go to HEX.
  - HEX: oVALID=1, oDATA=ascii(word[4*cnt+3 : 4*cnt]). On oVALID&&oREADY: if cnt>0, decrement cnt; else go to CR if ADD_CRLF, else go to IDLE.
  - CR: oVALID=1, oDATA=0x0D. Advances to LF on accept.
  - LF: oVALID=1, oDATA=0x0A, oLAST=1. Goes to IDLE on accept.
- Latency: the first character is presented on the cycle after input acceptance.
- Characters are consecutive, one per cycle, while oREADY=1.
- After the last accept there is one IDLE cycle before the next word can be taken. Throughput = NIB + 2*ADD_CRLF + 1 cycles per word.
- Backpressure: while oVALID && !oREADY, oDATA, oLAST, and oVALID hold stable. The counter and state do not change.
- iREADY=0 in every state except IDLE. iVALID asserted while busy is ignored, and the source must hold the word until accepted.
- Conversion:
  - n in 0-9 → 0x30+n.
  - n in 10-15 → 0x41+(n-10) when UPPERCASE=1, 0x61+(n-10) when UPPERCASE=0.
- oLAST is registered together with oDATA. It is never asserted when oVALID=0.
- oDATA returns to 0x00 in IDLE.
- All outputs are registered. No combinational path from iVALID or oREADY to any output.

Decomposition:
- Shared package holds:
  - ASCII_0=8'h30, ASCII_UA=8'h41, ASCII_LA=8'h61, ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - the state encoding (IDLE, HEX, CR, LF), 2 bits
- One combinational sub-module is natural: nibble_to_ascii. It takes a 4-bit nibble plus the UPPERCASE parameter and returns an 8-bit character. It mirrors the receive-side hex decoder and is reused by other debug formatters.

Test Plan:
1. Defaults, oREADY=1, iDATA=16'h1A2F. Required: 6 consecutive beats 0x31, 0x41, 0x32, 0x46, 0x0D, 0x0A, with oLAST only on 0x0A. First beat arrives one cycle after the handshake. iREADY is high again one cycle after the LF accept.
2. UPPERCASE=0, ADD_CRLF=0, iDATA=16'hBEEF. Required: 0x62, 0x65, 0x65, 0x66, with oLAST on the fourth beat and no CR/LF.
3. Backpressure on 16'h00F0: oREADY toggles 1,0,0,1,... Required: each character is held stable until accepted. Sequence is 0x30, 0x30, 0x46, 0x30, 0x0D, 0x0A with no drops or duplicates.
4. Second word 16'h1234 offered with iVALID held while busy. Required: iREADY=0 until the first word's LF is accepted. The second word is accepted in the following IDLE cycle and emitted intact.
5. RST_N pulsed low after the second character of 16'hABCD. Required: oVALID=0 and oDATA=0x00 immediately. After release, iREADY=1 and no residual characters appear. A new word 16'h0001 outputs "0001",CR,LF.
6. WORD_WIDTH=4, iDATA=4'h9. Required: 0x39, 0x0D, 0x0A, with oLAST on 0x0A. Boundary case: a single-nibble counter does not wrap.

Source files
------------

// File: rtl/hex_ascii_tx_formatter_pkg.sv
// Shared constants and state encoding for the hex ASCII transmit formatter
// and its nibble-to-character helper.
package hex_ascii_tx_formatter_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        CR   = 2'd2,
        LF   = 2'd3
    } state_t;

endpackage

// File: rtl/hex_ascii_tx_formatter_if.sv
// Word-in / character-out valid-ready bundle; the formatter is the slave side.
interface hex_ascii_tx_formatter_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  iVALID;
    logic                  iREADY;
    logic [WORD_WIDTH-1:0] iDATA;
    logic                  oVALID;
    logic                  oREADY;
    logic [7:0]            oDATA;
    logic                  oLAST;
    logic                  oBUSY;

    modport master (
        output iVALID, iDATA, oREADY,
        input  iREADY, oVALID, oDATA, oLAST, oBUSY
    );

    modport slave (
        input  iVALID, iDATA, oREADY,
        output iREADY, oVALID, oDATA, oLAST, oBUSY
    );
endinterface

// File: rtl/hex_ascii_tx_formatter_nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit; the inverse of the receive-side
// hex decoder and shared by the debug formatters.
module nibble_to_ascii
    import hex_ascii_tx_formatter_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_UA : ASCII_LA;

    always_comb begin
        if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
        else                ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
    end
endmodule

// File: rtl/hex_ascii_tx_formatter.sv
// Streams a binary word as ASCII hex characters, most significant nibble first,
// optionally followed by CR/LF. Every output is driven straight from a flop.
module hex_ascii_tx_formatter
    import hex_ascii_tx_formatter_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter bit ADD_CRLF   = 1'b1,
    parameter bit UPPERCASE  = 1'b1
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    hex_ascii_tx_formatter_if.slave         bus
);
    localparam int NIB = WORD_WIDTH / 4;
    localparam int CW  = $clog2(NIB) + 1;

    if ((WORD_WIDTH % 4) != 0 || WORD_WIDTH < 4) begin : g_width_check
        $error("hex_ascii_tx_formatter: WORD_WIDTH must be a multiple of 4 and >= 4");
    end

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ready_q, valid_q, last_q, busy_q;
    logic [7:0]            data_q;
    logic [7:0]            data_d;
    logic                  last_d;
    logic [3:0]            nib_d;
    logic [7:0]            hex_char;

    // NOTE: every variable written in an always_comb gets a default on entry,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.iVALID && ready_q) begin
                word_d  = bus.iDATA;
                cnt_d   = CW'(NIB - 1);
                state_d = HEX;
            end
            HEX: if (valid_q && bus.oREADY) begin
                if (cnt_q != '0) cnt_d   = cnt_q - CW'(1);
                else             state_d = ADD_CRLF ? CR : IDLE;
            end
            CR:      if (bus.oREADY) state_d = LF;
            LF:      if (bus.oREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they can be registered
    // and still appear the cycle right after the input handshake.
    assign nib_d = 4'(word_d >> (4 * cnt_d));

    nibble_to_ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nibble_to_ascii (
        .nibble (nib_d),
        .ascii  (hex_char)
    );

    always_comb begin
        data_d = 8'h00;
        last_d = 1'b0;
        case (state_d)
            HEX: begin
                data_d = hex_char;
                last_d = !ADD_CRLF && (cnt_d == '0);
            end
            CR:  data_d = ASCII_CR;
            LF: begin
                data_d = ASCII_LF;
                last_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == IDLE);
            valid_q <= (state_d != IDLE);
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.iREADY = ready_q;
    assign bus.oVALID = valid_q;
    assign bus.oDATA  = data_q;
    assign bus.oLAST  = last_q;
    assign bus.oBUSY  = busy_q;
endmodule

// File: tb/tb_hex_ascii_tx_formatter.sv
// Self-checking bench: three formatter configurations against a queue-based
// model of the expected character stream, with random words and backpressure.
module tb_hex_ascii_tx_formatter;

    typedef logic [7:0] char_q_t[$];

    logic clk;
    logic rst_n = 1'b1;

    logic        in_valid [3];
    logic [15:0] in_data;
    logic        o_ready  [3];
    logic        i_ready  [3];
    logic        o_valid  [3];
    logic [7:0]  o_data   [3];
    logic        o_last   [3];
    logic        o_busy   [3];

    int n_cmp = 0;
    int n_bad = 0;

    // 0: defaults; 1: lowercase, no CR/LF; 2: single-nibble word
    hex_ascii_tx_formatter_if #(.WORD_WIDTH(16)) if_a ();
    hex_ascii_tx_formatter_if #(.WORD_WIDTH(16)) if_b ();
    hex_ascii_tx_formatter_if #(.WORD_WIDTH(4))  if_c ();

    hex_ascii_tx_formatter #(.WORD_WIDTH(16), .ADD_CRLF(1'b1), .UPPERCASE(1'b1))
        dut_a (.CLK(clk), .RST_N(rst_n), .bus(if_a.slave));
    hex_ascii_tx_formatter #(.WORD_WIDTH(16), .ADD_CRLF(1'b0), .UPPERCASE(1'b0))
        dut_b (.CLK(clk), .RST_N(rst_n), .bus(if_b.slave));
    hex_ascii_tx_formatter #(.WORD_WIDTH(4), .ADD_CRLF(1'b1), .UPPERCASE(1'b1))
        dut_c (.CLK(clk), .RST_N(rst_n), .bus(if_c.slave));

    assign if_a.iVALID = in_valid[0];
    assign if_b.iVALID = in_valid[1];
    assign if_c.iVALID = in_valid[2];
    assign if_a.iDATA  = in_data;
    assign if_b.iDATA  = in_data;
    assign if_c.iDATA  = in_data[3:0];
    assign if_a.oREADY = o_ready[0];
    assign if_b.oREADY = o_ready[1];
    assign if_c.oREADY = o_ready[2];

    assign i_ready[0] = if_a.iREADY;  assign i_ready[1] = if_b.iREADY;  assign i_ready[2] = if_c.iREADY;
    assign o_valid[0] = if_a.oVALID;  assign o_valid[1] = if_b.oVALID;  assign o_valid[2] = if_c.oVALID;
    assign o_data[0]  = if_a.oDATA;   assign o_data[1]  = if_b.oDATA;   assign o_data[2]  = if_c.oDATA;
    assign o_last[0]  = if_a.oLAST;   assign o_last[1]  = if_b.oLAST;   assign o_last[2]  = if_c.oLAST;
    assign o_busy[0]  = if_a.oBUSY;   assign o_busy[1]  = if_b.oBUSY;   assign o_busy[2]  = if_c.oBUSY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected character stream for one word on configuration sel.
    function automatic char_q_t model(input int sel, input logic [15:0] word);
        char_q_t q;
        int  nib   = (sel == 2) ? 1 : 4;
        bit  crlf  = (sel != 1);
        bit  upper = (sel != 1);
        for (int i = nib - 1; i >= 0; i--) begin
            int n = int'((word >> (4 * i)) & 16'hF);
            if (n < 10) q.push_back(8'(48 + n));
            else        q.push_back(8'((upper ? 65 : 97) + n - 10));
        end
        if (crlf) begin
            q.push_back(8'd13);
            q.push_back(8'd10);
        end
        return q;
    endfunction

    // Offer a word at a falling edge; returns at the falling edge after the handshake.
    task automatic send_word(input int sel, input logic [15:0] word, input string name);
        int wait_cyc = 0;
        while (i_ready[sel] !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (wait_cyc >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: iREADY never rose, got %b required 1", name, i_ready[sel]);
        end
        in_valid[sel] = 1'b1;
        in_data       = word;
        @(negedge clk);
        in_valid[sel] = 1'b0;
    endtask

    // Collect one word's beats. mode 0: always ready, 1: random, 2: pattern 1,0,0.
    task automatic collect(input int sel, input logic [15:0] word, input int mode, input string name);
        char_q_t    exp;
        int         idx  = 0;
        int         cyc  = 0;
        bit         held = 1'b0;
        bit         r;
        logic [7:0] hd   = 8'h00;
        logic       hl   = 1'b0;
        exp = model(sel, word);
        while (idx < exp.size() && cyc < 200) begin
            n_cmp++;
            if (o_valid[sel] !== 1'b1 || o_busy[sel] !== 1'b1 || i_ready[sel] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s beat %0d flags: valid/busy/iready=%b/%b/%b required 1/1/0",
                         name, idx, o_valid[sel], o_busy[sel], i_ready[sel]);
                break;
            end
            if (held) begin
                n_cmp++;
                if (o_data[sel] !== hd || o_last[sel] !== hl) begin
                    n_bad++;
                    $display("FAIL %s hold beat %0d: data=%h last=%b required %h/%b",
                             name, idx, o_data[sel], o_last[sel], hd, hl);
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc % 3 == 0);
            endcase
            if (r) begin
                n_cmp++;
                if (o_data[sel] !== exp[idx] || o_last[sel] !== (idx == exp.size() - 1)) begin
                    n_bad++;
                    $display("FAIL %s beat %0d: data=%h last=%b required %h/%b",
                             name, idx, o_data[sel], o_last[sel], exp[idx], (idx == exp.size() - 1));
                end
                idx++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hd   = o_data[sel];
                hl   = o_last[sel];
            end
            o_ready[sel] = r;
            @(negedge clk);
            cyc++;
        end
        o_ready[sel] = 1'b0;
        n_cmp++;
        if (idx != exp.size() || o_valid[sel] !== 1'b0 || o_data[sel] !== 8'h00 ||
            o_last[sel] !== 1'b0 || i_ready[sel] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s end: beats=%0d valid=%b data=%h last=%b iready=%b required %0d/0/00/0/1",
                     name, idx, o_valid[sel], o_data[sel], o_last[sel], i_ready[sel], exp.size());
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (i_ready[s] !== 1'b0 || o_valid[s] !== 1'b0 || o_data[s] !== 8'h00 ||
                o_last[s] !== 1'b0 || o_busy[s] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d: iready/valid/data/last/busy=%b/%b/%h/%b/%b required 0/0/00/0/0",
                         s, i_ready[s], o_valid[s], o_data[s], o_last[s], o_busy[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (i_ready[s] !== 1'b1 || o_valid[s] !== 1'b0) begin
                n_bad++;
                $display("FAIL post-reset dut%0d: iready=%b valid=%b required 1/0", s, i_ready[s], o_valid[s]);
            end
        end
    endtask

    task automatic test_defaults();
        send_word(0, 16'h1A2F, "defaults");
        collect(0, 16'h1A2F, 0, "defaults");
    endtask

    task automatic test_lowercase_no_crlf();
        send_word(1, 16'hBEEF, "lower");
        collect(1, 16'hBEEF, 0, "lower");
    endtask

    task automatic test_backpressure();
        send_word(0, 16'h00F0, "backpressure");
        collect(0, 16'h00F0, 2, "backpressure");
    endtask

    task automatic test_back_to_back();
        send_word(0, 16'hC0DE, "b2b_first");
        in_valid[0] = 1'b1;
        in_data     = 16'h1234;
        collect(0, 16'hC0DE, 0, "b2b_first");
        @(negedge clk);
        in_valid[0] = 1'b0;
        collect(0, 16'h1234, 0, "b2b_second");
    endtask

    task automatic test_midword_reset();
        send_word(0, 16'hABCD, "midreset");
        o_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid[0] !== 1'b0 || o_data[0] !== 8'h00 || o_last[0] !== 1'b0 ||
            o_busy[0] !== 1'b0 || i_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset async: valid/data/last/busy/iready=%b/%h/%b/%b/%b required 0/00/0/0/0",
                     o_valid[0], o_data[0], o_last[0], o_busy[0], i_ready[0]);
        end
        o_ready[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (o_valid[0] !== 1'b0 || i_ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL midreset residue cycle %0d: valid=%b iready=%b required 0/1",
                         c, o_valid[0], i_ready[0]);
            end
        end
        send_word(0, 16'h0001, "midreset_new");
        collect(0, 16'h0001, 0, "midreset_new");
    endtask

    task automatic test_single_nibble();
        send_word(2, 16'h0009, "single_nibble");
        collect(2, 16'h0009, 0, "single_nibble");
        send_word(2, 16'h000F, "single_nibble_f");
        collect(2, 16'h000F, 2, "single_nibble_f");
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 6; k++) begin
                logic [15:0] w = 16'($urandom);
                if (s == 2) w = w & 16'h000F;
                send_word(s, w, "random");
                collect(s, w, (k % 2 == 0) ? 1 : 0, "random");
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            in_valid[s] = 1'b0;
            o_ready[s]  = 1'b0;
        end
        in_data = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_defaults();
        test_lowercase_no_crlf();
        test_backpressure();
        test_back_to_back();
        test_midword_reset();
        test_single_nibble();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
